// File: rtl/squaring_pipe_nbit.sv
// Elastic signed-operand squarer: carry-save reduction of the squaring partial products
// spread over STAGES registers. Define SQUARER_APPROX_ABS_EN for one's-complement magnitude.
module squaring_pipe_nbit #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WIDTH-1:0]           out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES+1);

    // Handshake: a side transfers on any rising edge where its valid and ready are both 1;
    // ready never waits on valid of the same side, and held data stays stable while stalled.

    logic [WIDTH-1:0]  mag;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_q;

`ifdef SQUARER_APPROX_ABS_EN
    assign mag = in_data[WIDTH-1] ? ~in_data : in_data;
`else
    assign mag = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
`endif

    // Row i of the squaring matrix: x[i] on the diagonal at 2i, x[i]&x[j] (j>i) at i+j+1.
    function automatic logic [2*WIDTH-1:0] pp_row(input logic [WIDTH-1:0] x, input int i);
        logic [2*WIDTH-1:0] r;
        r        = '0;
        r[2*i]   = x[i];
        for (int j = i + 1; j < WIDTH; j++) begin
            r[i+j+1] = x[i] & x[j];
        end
        return r;
    endfunction

    always_comb begin
        logic free;
        adv  = '0;
        free = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = valid_q[k] && free;
            free   = !valid_q[k] || adv[k];
        end
    end

    assign in_ready = !valid_q[0] || adv[0];
    assign in_fire  = in_valid && in_ready;
    assign out_fire = adv[STAGES-1];
    assign out_valid = valid_q[STAGES-1];
    assign occupancy = occ_q;

    always_comb begin
        load    = '0;
        load[0] = in_fire;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= 1'b1;
                end else if (adv[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (in_fire && !out_fire) begin
                occ_q <= occ_q + 1'b1;
            end else if (out_fire && !in_fire) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = (k * WIDTH) / STAGES;
        localparam int HI = ((k + 1) * WIDTH) / STAGES;

        logic [WIDTH-1:0]   x_in;
        logic [2*WIDTH-1:0] s_in, c_in, s_d, c_d, s_q, c_q;

        if (k == 0) begin : g_src
            assign x_in = mag;
            assign s_in = '0;
            assign c_in = '0;
        end else begin : g_src
            assign x_in = g_stage[k-1].g_carry.x_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
        end

        // Fold this stage's share of rows into the sum/carry pair with 3:2 compressors.
        always_comb begin
            logic [2*WIDTH-1:0] row, maj;
            row = '0;
            maj = '0;
            s_d = s_in;
            c_d = c_in;
            for (int i = LO; i < HI; i++) begin
                row = pp_row(x_in, i);
                maj = (s_d & c_d) | (s_d & row) | (c_d & row);
                s_d = s_d ^ c_d ^ row;
                c_d = maj << 1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= '0;
            end else if (load[k]) begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_carry
            logic [WIDTH-1:0] x_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= '0;
                end else if (load[k]) begin
                    x_q <= x_in;
                end
            end
        end
    end

    assign out_data = g_stage[STAGES-1].s_q + g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_squaring_pipe_nbit.sv
// Directed-vector and scoreboard bench for squaring_pipe_nbit at WIDTH=8, STAGES=2.
module tb_squaring_pipe_nbit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  squaring_pipe_nbit #(.WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sq_model(input logic [7:0] d);
    int m;
`ifdef SQUARER_APPROX_ABS_EN
    m = d[7] ? int'(8'(~d)) : int'(d);
`else
    m = d[7] ? 256 - int'(d) : int'(d);
`endif
    return 16'(m * m);
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input logic [7:0] d, input logic [15:0] exp);
    step();
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    @(negedge clk);
    chk("vec_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("vec_lat1_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("vec_lat2_valid", out_valid, 1);
    chk("vec_data", out_data, exp);
    chk("vec_occ", occupancy, 1);
    step();
    @(negedge clk);
    chk("vec_drained_valid", out_valid, 0);
    chk("vec_drained_occ", occupancy, 0);
  endtask

  // scoreboard
  logic [15:0] exp_q[$];
  logic        sb_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  int          n_out = 0;
  int          first_out_cyc = -1;
  int          last_out_cyc = -1;

  always @(negedge clk) begin
    if (sb_en) begin
      chk("occ_vs_sb", occupancy, exp_q.size());
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          chk("sb_data", out_data, exp_q.pop_front());
          n_out++;
          if (first_out_cyc < 0) first_out_cyc = cyc;
          last_out_cyc = cyc;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(sq_model(in_data));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  d;
    logic [15:0] ex;
    logic [15:0] ap;
  } vec_t;

  vec_t vecs[12];

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h05, 16'd25,    16'd25};
    vecs[1]  = '{8'h80, 16'd16384, 16'd16129};
    vecs[2]  = '{8'hFF, 16'd1,     16'd0};
    vecs[3]  = '{8'h7F, 16'd16129, 16'd16129};
    vecs[4]  = '{8'h00, 16'd0,     16'd0};
    vecs[5]  = '{8'h01, 16'd1,     16'd1};
    vecs[6]  = '{8'hFE, 16'd4,     16'd1};
    vecs[7]  = '{8'h81, 16'd16129, 16'd15876};
    vecs[8]  = '{8'h10, 16'd256,   16'd256};
    vecs[9]  = '{8'hF0, 16'd256,   16'd225};
    vecs[10] = '{8'h0C, 16'd144,   16'd144};
    vecs[11] = '{8'hC0, 16'd4096,  16'd3969};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) begin
`ifdef SQUARER_APPROX_ABS_EN
      run_vec(vecs[i].d, vecs[i].ap);
`else
      run_vec(vecs[i].d, vecs[i].ex);
`endif
    end

    // back-pressure: 3 offered while stalled, only 2 fit
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd3;
    @(negedge clk);
    chk("bp_ready0", in_ready, 1);
    step();
    in_data = 8'd4;
    @(negedge clk);
    chk("bp_ready1", in_ready, 1);
    step();
    in_data = 8'd5;
    @(negedge clk);
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_occ", occupancy, 2);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_data", out_data, 9);
    step();
    @(negedge clk);
    chk("bp_hold_data", out_data, 9);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_occ", occupancy, 2);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_data", out_data, 9);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out16", out_data, 16);
    chk("bp_both_occ", occupancy, 2);
    step();
    @(negedge clk);
    chk("bp_out25", out_data, 25);
    chk("bp_out25_valid", out_valid, 1);
    chk("bp_out25_occ", occupancy, 1);
    step();
    @(negedge clk);
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_occ", occupancy, 0);

    // reset while full discards everything in flight
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd6;
    step();
    in_data = 8'd7;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_full_occ", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_data", out_data, 0);
    step();
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end
`ifdef SQUARER_APPROX_ABS_EN
    run_vec(8'h09, 16'd81);
`else
    run_vec(8'hF7, 16'd81);
`endif

    // full-rate stream of every operand
    exp_q.delete();
    n_out = 0;
    first_out_cyc = -1;
    sb_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      step();
      in_valid  = 1'b1;
      in_data   = 8'(i);
      out_ready = 1'b1;
      @(negedge clk);
      chk("stream_ready", in_ready, 1);
    end
    step();
    drain("stream_drain");
    chk("stream_count", n_out, 256);
    chk("stream_rate", last_out_cyc - first_out_cyc, 255);

    // random valid/ready traffic
    n_out = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
    end
    step();
    drain("rand_drain");
    sb_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
